onehot_capture_encoder: RTL



---
 rtl/onehot_capture_encoder_pkg.sv | 19 +
 rtl/onehot_capture_encoder_sync_debounce.sv | 29 ++
 rtl/onehot_capture_encoder.sv | 83 ++++++++
 3 files changed

// File: rtl/onehot_capture_encoder_pkg.sv
// onehot_capture_encoder_pkg: shared state/classification types, pin map and one-hot helpers
package onehot_capture_encoder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HELD = 2'd2} state_t;
    typedef enum logic [1:0] {CLS_ZERO = 2'd0, CLS_ONE = 2'd1, CLS_MULTI = 2'd2} cls_t;
    localparam int PIN_CLK = 0;
    localparam int PIN_RST = 1;
    localparam int PIN_LINE_LO = 2;
    localparam int PIN_ACK = 6;
    localparam int PIN_HOLD = 7;
    localparam int OUT_VALID = 2;
    localparam int OUT_ERR = 3;
    localparam int OUT_CNT_LO = 4;
    function automatic cls_t classify(input logic [3:0] v);
        return v == 4'd0 ? CLS_ZERO : (v & (v - 4'd1)) == 4'd0 ? CLS_ONE : CLS_MULTI;
    endfunction
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/onehot_capture_encoder_sync_debounce.sv
// sync_debounce: 2-flop synchroniser followed by a stability filter of STABLE_CYCLES matching samples
module sync_debounce #(
    parameter int W = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] deb
);
    localparam logic [3:0] MAX = 4'(STABLE_CYCLES);
    logic [W-1:0] s1, s2, prev;
    logic [3:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            prev <= '0;
            cnt <= '0;
            deb <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            prev <= s2;
            cnt <= s2 != prev ? 4'd0 : cnt == MAX ? cnt : cnt + 4'd1;
            if (s2 == prev && cnt == MAX - 4'd1) deb <= s2;
        end
    end
endmodule

// File: rtl/onehot_capture_encoder.sv
// onehot_capture_encoder: recovers the 2-bit index from four async one-hot lines with hold/ack and sticky error
module onehot_capture_encoder
    import onehot_capture_encoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    logic clk, rst;
    logic [3:0] deb;
    logic ack_s1, ack_s, ack_s_d, hold_s1, hold_s, ack_rise;
    state_t state, state_n;
    logic [1:0] code, code_n, idx;
    logic [3:0] cnt, cnt_n;
    logic valid, err, err_n;
    cls_t cls;
    assign clk = io_in[PIN_CLK];
    assign rst = io_in[PIN_RST];
    sync_debounce #(.W(4), .STABLE_CYCLES(STABLE_CYCLES)) u_deb (
        .clk(clk),
        .rst(rst),
        .d(io_in[PIN_LINE_LO +: 4]),
        .deb(deb)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            {ack_s1, ack_s, ack_s_d, hold_s1, hold_s} <= '0;
        end else begin
            ack_s1 <= io_in[PIN_ACK];
            ack_s <= ack_s1;
            ack_s_d <= ack_s;
            hold_s1 <= io_in[PIN_HOLD];
            hold_s <= hold_s1;
        end
    end
    assign ack_rise = ack_s & ~ack_s_d;
    assign cls = classify(deb);
    assign idx = onehot_idx(deb);
    // A multi-hot pattern freezes everything but err; setting err beats an ack clearing it
    always_comb begin
        state_n = state;
        code_n = code;
        cnt_n = cnt;
        err_n = cls == CLS_MULTI ? 1'b1 : err & ~ack_rise;
        if (cls != CLS_MULTI) begin
            case (state)
                IDLE: if (cls == CLS_ONE) begin
                    state_n = hold_s ? HELD : ACTIVE;
                    code_n = idx;
                    cnt_n = cnt + 4'd1;
                end
                ACTIVE: if (hold_s) state_n = HELD;
                else if (cls == CLS_ZERO) state_n = IDLE;
                else if (idx != code) begin
                    code_n = idx;
                    cnt_n = cnt + 4'd1;
                end
                HELD: if (ack_rise) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            code <= '0;
            cnt <= '0;
            err <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            code <= code_n;
            cnt <= cnt_n;
            err <= err_n;
            valid <= state_n != IDLE;
        end
    end
    assign io_out[1:0] = code;
    assign io_out[OUT_VALID] = valid;
    assign io_out[OUT_ERR] = err;
    assign io_out[OUT_CNT_LO +: 4] = cnt;
endmodule
